// File: rtl/sd_cmd_start_detect_pkg.sv
// Shared definitions for the SD host command start detector: FSM encoding and
// the command index that means "no command".
package sd_host_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    localparam int CMD_IDX_NONE = 0;

endpackage

// File: rtl/sd_cmd_start_detect_if.sv
// Command-register / command-engine signal bundle. The master drives the
// software and engine inputs; the slave is the detector.
interface sd_cmd_start_detect_if #(
    parameter int CMD_W = 6
);
    logic [CMD_W-1:0] command_register;
    logic             enable;
    logic             cmd_done;
    logic             clear_flags;
    logic             start_pulse;
    logic [CMD_W-1:0] cmd_index;
    logic             busy;
    logic             pending;
    logic             overrun;
    logic             timeout;

    modport master (
        output command_register, enable, cmd_done, clear_flags,
        input  start_pulse, cmd_index, busy, pending, overrun, timeout
    );

    modport slave (
        input  command_register, enable, cmd_done, clear_flags,
        output start_pulse, cmd_index, busy, pending, overrun, timeout
    );
endinterface

// File: rtl/sd_cmd_start_detect_debounce.sv
// Change detector for the command register: a new nonzero value that holds for
// DEBOUNCE sampled cycles while enabled produces a single-cycle detect.
module sd_cmd_debounce
    import sd_host_defs::*;
#(
    parameter int CMD_W    = 6,
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] sample_i,
    input  logic             enable_i,
    output logic             detect_o,
    output logic [CMD_W-1:0] index_o
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [CMD_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic             armed_q, armed_d;
    logic             changed;
    logic             stable;

    assign changed  = (sample_i != prev_q);
    assign stable   = (stab_q == CNT_MAX);
    assign detect_o = armed_q && stable && enable_i && (prev_q != CMD_W'(CMD_IDX_NONE));
    assign index_o  = prev_q;

    // Armed is consumed once the value has settled, whether or not it fired,
    // so a held value can never retrigger.
    always_comb begin
        prev_d  = prev_q;
        stab_d  = stab_q;
        armed_d = armed_q;
        if (changed) begin
            prev_d  = sample_i;
            stab_d  = CNT_W'(1);
            armed_d = enable_i;
        end else begin
            if (!stable) stab_d = stab_q + CNT_W'(1);
            if (!enable_i || stable) armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            stab_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            stab_q  <= stab_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sd_cmd_start_detect.sv
// SD host command start detector: issues debounced command indices to the
// command engine, tracks completion/timeout and parks one start while busy.
module sd_cmd_start_detect
    import sd_host_defs::*;
#(
    parameter int CMD_W     = 6,
    parameter int DEBOUNCE  = 2,
    parameter int TIMEOUT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    sd_cmd_start_detect_if.slave   bus
);
    // Last count before the timer would reach all-ones; the command ends on that edge.
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q;
    logic                 start_q;
    logic                 busy_q;
    logic                 pend_q;
    logic                 overrun_q;
    logic                 timeout_q;
    logic [CMD_W-1:0]     idx_q;
    logic [CMD_W-1:0]     pend_idx_q;
    logic [TIMEOUT_W-1:0] timer_q;

    logic                 detect;
    logic [CMD_W-1:0]     det_idx;
    logic                 in_wait;
    logic                 expire;
    logic                 cmd_end;

    sd_cmd_debounce #(
        .CMD_W    (CMD_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .sample_i (bus.command_register),
        .enable_i (bus.enable),
        .detect_o (detect),
        .index_o  (det_idx)
    );

    assign in_wait = (state_q == ST_WAIT_DONE);
    assign expire  = in_wait && (timer_q == TIMER_LAST) && !bus.cmd_done;
    assign cmd_end = in_wait && (bus.cmd_done || (timer_q == TIMER_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            idx_q      <= '0;
            pend_idx_q <= '0;
            timer_q    <= '0;
        end else begin
            start_q <= 1'b0;
            if (bus.clear_flags) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (detect) begin
                        idx_q   <= det_idx;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    timer_q <= timer_q + TIMEOUT_W'(1);
                    if (expire) timeout_q <= 1'b1;
                    if (cmd_end) begin
                        // A parked start has priority; a same-cycle detect refills the slot.
                        if (pend_q) begin
                            idx_q   <= pend_idx_q;
                            start_q <= 1'b1;
                            state_q <= ST_ISSUE;
                            if (detect) pend_idx_q <= det_idx;
                            else        pend_q     <= 1'b0;
                        end else if (detect) begin
                            idx_q   <= det_idx;
                            start_q <= 1'b1;
                            state_q <= ST_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

            if (detect && busy_q && !cmd_end) begin
                if (!pend_q) begin
                    pend_q     <= 1'b1;
                    pend_idx_q <= det_idx;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.start_pulse = start_q;
    assign bus.cmd_index   = idx_q;
    assign bus.busy        = busy_q;
    assign bus.pending     = pend_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_sd_cmd_start_detect.sv
// Scoreboard bench for sd_cmd_start_detect: stimulus queues expected starts
// (index and cycle); a negedge monitor pops and compares on each start_pulse.
module tb_sd_cmd_start_detect;
    localparam int CMD_W = 6;
    localparam int DEB   = 2;
    localparam int TW    = 4;

    logic clk = 1'b0;
    logic reset;

    sd_cmd_start_detect_if #(.CMD_W(CMD_W)) bus ();

    sd_cmd_start_detect #(
        .CMD_W     (CMD_W),
        .DEBOUNCE  (DEB),
        .TIMEOUT_W (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CMD_W-1:0] idx;
        int               at;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Value written now is sampled at the next edge; start appears DEB edges later.
    task automatic expect_start(input int idx);
        exp_t e;
        e.idx = CMD_W'(idx);
        e.at  = cyc + 1 + DEB;
        expq.push_back(e);
    endtask

    task automatic pulse_done();
        bus.cmd_done = 1'b1;
        tick(1);
        bus.cmd_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},   int'(bus.start_pulse), 0);
        chk({tag, "_index"},   int'(bus.cmd_index),   0);
        chk({tag, "_busy"},    int'(bus.busy),        0);
        chk({tag, "_pending"}, int'(bus.pending),     0);
        chk({tag, "_overrun"}, int'(bus.overrun),     0);
        chk({tag, "_timeout"}, int'(bus.timeout),     0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.start_pulse) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got index %0d at cycle %0d, expected no start",
                         bus.cmd_index, cyc);
            end else begin
                e = expq.pop_front();
                chk("start_index", int'(bus.cmd_index), int'(e.idx));
                chk("start_cycle", cyc, e.at);
                chk("start_busy",  int'(bus.busy), 1);
            end
        end
    end

    initial begin
        reset                = 1'b1;
        bus.command_register = '0;
        bus.enable           = 1'b1;
        bus.cmd_done         = 1'b0;
        bus.clear_flags      = 1'b0;
        tick(2);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);

        // Basic start: 0 -> 4
        bus.command_register = 6'd4;
        expect_start(4);
        tick(2);
        chk("s1_busy_early", int'(bus.busy), 0);
        tick(1);
        chk("s1_busy", int'(bus.busy), 1);
        chk("s1_index", int'(bus.cmd_index), 4);
        tick(3);
        chk("s1_busy_wait", int'(bus.busy), 1);
        pulse_done();
        chk("s1_busy_after_done", int'(bus.busy), 0);

        // Short-lived 4 then 7: only 7 issues
        bus.command_register = 6'd0;
        tick(3);
        bus.command_register = 6'd4;
        tick(1);
        bus.command_register = 6'd7;
        expect_start(7);
        tick(3);
        chk("s2_index", int'(bus.cmd_index), 7);
        tick(1);
        pulse_done();
        chk("s2_busy_after_done", int'(bus.busy), 0);

        // Pending slot and overrun
        bus.command_register = 6'd9;
        expect_start(9);
        tick(3);
        bus.command_register = 6'd1;
        tick(3);
        chk("s3_pending_set", int'(bus.pending), 1);
        chk("s3_overrun_clear", int'(bus.overrun), 0);
        bus.command_register = 6'd3;
        tick(3);
        chk("s3_pending_held", int'(bus.pending), 1);
        chk("s3_overrun_set", int'(bus.overrun), 1);
        chk("s3_busy", int'(bus.busy), 1);
        bus.cmd_done = 1'b1;
        begin
            exp_t e;
            e.idx = CMD_W'(1);
            e.at  = cyc + 1;
            expq.push_back(e);
        end
        tick(1);
        bus.cmd_done = 1'b0;
        chk("s3_pending_drained", int'(bus.pending), 0);
        chk("s3_index_pending", int'(bus.cmd_index), 1);
        tick(1);
        pulse_done();
        chk("s3_busy_after_done", int'(bus.busy), 0);
        chk("s3_overrun_sticky", int'(bus.overrun), 1);
        bus.clear_flags = 1'b1;
        tick(1);
        bus.clear_flags = 1'b0;
        chk("s3_overrun_cleared", int'(bus.overrun), 0);

        // Timeout after 15 WAIT_DONE cycles
        bus.command_register = 6'd5;
        expect_start(5);
        tick(3);
        tick(15);
        chk("s4_timeout_early", int'(bus.timeout), 0);
        chk("s4_busy_early", int'(bus.busy), 1);
        tick(1);
        chk("s4_timeout_set", int'(bus.timeout), 1);
        chk("s4_busy_after_to", int'(bus.busy), 0);
        bus.clear_flags = 1'b1;
        tick(1);
        bus.clear_flags = 1'b0;
        chk("s4_timeout_cleared", int'(bus.timeout), 0);

        // cmd_done on the expiry edge: done wins
        bus.command_register = 6'd0;
        tick(3);
        bus.command_register = 6'd5;
        expect_start(5);
        tick(3);
        tick(15);
        bus.cmd_done = 1'b1;
        tick(1);
        bus.cmd_done = 1'b0;
        chk("s4_done_wins_timeout", int'(bus.timeout), 0);
        chk("s4_done_wins_busy", int'(bus.busy), 0);

        // Enable gating and same-value rewrite
        bus.enable = 1'b0;
        bus.command_register = 6'd6;
        tick(4);
        bus.enable = 1'b1;
        tick(4);
        chk("s5_no_start_busy", int'(bus.busy), 0);
        chk("s5_no_start_pending", int'(bus.pending), 0);
        bus.command_register = 6'd2;
        expect_start(2);
        tick(3);
        chk("s5_index", int'(bus.cmd_index), 2);
        tick(1);
        pulse_done();
        bus.command_register = 6'd2;
        tick(4);
        chk("s5_rewrite_busy", int'(bus.busy), 0);

        // Reset during WAIT_DONE, value held across reset
        bus.command_register = 6'd7;
        expect_start(7);
        tick(3);
        tick(3);
        chk("s6_busy_before_reset", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk_zero("s6_reset_mid");
        tick(1);
        reset = 1'b0;
        expect_start(7);
        tick(3);
        chk("s6_busy_restart", int'(bus.busy), 1);
        chk("s6_index_restart", int'(bus.cmd_index), 7);
        tick(1);
        pulse_done();
        chk("s6_busy_after_done", int'(bus.busy), 0);

        tick(2);
        chk("scoreboard_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
